wakeup_select_ctrl: RTL
=======================

// Module: wakeup_select_ctrl
// PURPOSE
// - Wakeup/select scheduler on the Wakeup side of the Dispatch<->Wakeup handshake.
// - Holds up to NUM_ENTRIES dispatched instrs with per-source dependency masks; clears bits on producer
//   completion broadcasts; selects the oldest ready entry for issue, one per cycle.
// - Sits between Dispatch (entry_free/dispatch_valid) and the FU issue stage.
// PARAMETERS
// - NUM_FUS      4   number of functional units; dependency mask width is 2*NUM_FUS
// - NUM_ENTRIES  8   scheduler entries (>=2)
// - IDX_W        $clog2(NUM_ENTRIES)   entry index width
// PORTS
// - clk             in   1          core clock
// - rst             in   1          sync active-high reset
// - dispatch_valid  in   1          dispatch instr valid this cycle
// - src1_dp_en      in   1          src1 waits on a producer
// - src2_dp_en      in   1          src2 waits on a producer
// - src1_dp_loc     in   2*NUM_FUS  src1 producer slot mask (DLT read)
// - src2_dp_loc     in   2*NUM_FUS  src2 producer slot mask (DLT read)
// - entry_free      out  1          room for one more instr
// - disp_idx        out  IDX_W      entry allocated to the current dispatch
// - wakeup_vec      in   2*NUM_FUS  producer slots completing this cycle (broadcast)
// - flush           in   1          squash all entries
// - issue_valid     out  1          an entry is ready
// - issue_idx       out  IDX_W      oldest ready entry
// - issue_ready     in   1          issue stage accepts issue_idx this cycle
// BEHAVIOUR
// - Reset/flush (next edge): all valid=0; masks=0; count=0; entry_free=1; issue_valid=0; disp_idx=0.
//   Flush beats dispatch and issue in the same cycle.
// - entry_free = (count != NUM_ENTRIES); registered count, so it does not depend on same-cycle issue.
// - Alloc: disp_idx = lowest-index invalid entry, combinational.
//   If entry_free==0, dispatch_valid is ignored (protocol violation; assertion fires).
// - Dispatch write (edge): valid=1;
//   m1 = src1_dp_en ? src1_dp_loc : 0; m2 likewise;
//   stored masks = m & ~wakeup_vec (same-cycle bypass); age = youngest.
// - Wakeup (edge): every valid entry's m1/m2 &= ~wakeup_vec.
//   Bits not set are unaffected; a wakeup for an absent slot is a no-op.
// - Ready = valid & m1==0 & m2==0, evaluated on registered state.
//   Bypassed dispatch becomes ready the cycle after the write; 1-cycle dispatch->issue minimum.
// - Select: age matrix NxN; oldest ready wins. issue_valid/issue_idx are combinational from registers.
//   issue_idx holds while issue_valid && !issue_ready, unless an older entry becomes ready.
// - Issue: on issue_valid && issue_ready, entry valid=0 at the edge; the slot is allocatable next cycle.
// - Count: +1 on accepted dispatch, -1 on issue; simultaneous = unchanged.
//   A full queue with an issue still holds entry_free=0 this cycle.
// - Age matrix: on alloc of entry i, row i = current valid vector (older than i); column i cleared.
//   Entries never age-wrap.
// CONFIGURATION
// - WAKEUP_PERF_CNT_EN defined adds:
//   - outputs perf_full_cyc[31:0] (cycles with entry_free==0)
//   - perf_issue_cnt[31:0] (accepted issues)
//   - both reset to 0, saturating at all-ones, cleared by rst only (not flush).
// - Undefined: the ports and counters are absent; no other change.
// TESTING
// - Reset then dispatch with src1/2_dp_en=0 -> entry 0 valid; next cycle issue_valid=1, issue_idx=0;
//   issue_ready=1 -> count 0, entry_free=1.
// - Dispatch with src1_dp_loc=8'h04, then wakeup_vec=8'h04 two cycles later
//   -> issue_valid=0 until the cycle after the wakeup, then issue_idx=0.
// - Dispatch with loc=8'h10 and wakeup_vec=8'h10 in the same cycle -> ready next cycle (bypass).
// - Fill 8 entries, all blocked -> entry_free=0; dispatch_valid=1 ignored, count stays 8;
//   clear entry 5 -> issue 5, entry_free=1 next cycle, re-dispatch gets disp_idx=5.
// - Entries 3 (older) and 1 (younger) both ready -> issue_idx=3 first, then 1.
// - Flush while full with issue_ready=1 -> all invalid, count=0, no issue;
//   PERF_EN: perf_full_cyc retains its value.

Source files
------------

// File: rtl/wakeup_select_ctrl.sv
// Purpose : wakeup/select scheduler holding dispatched instrs until their producers complete,
//           then issuing the oldest ready entry, one per cycle.
// Latency : dispatch -> issue_valid 1 cycle minimum; wakeup -> issue_valid 1 cycle.
// Backpressure: entry_free drops when all entries are occupied; issue_idx holds while
//           issue_valid && !issue_ready (an older entry becoming ready may take over).
//
// Ports:
//   clk, rst                     core clock, synchronous active-high reset
//   dispatch_valid               dispatch of one instr this cycle (honoured only when entry_free)
//   src1/2_dp_en, src1/2_dp_loc  per-source "waits on producer" flag and producer slot mask
//   entry_free, disp_idx         room available / entry the current dispatch will occupy
//   wakeup_vec                   producer slots completing this cycle
//   flush                        squash every entry (wins over dispatch and issue)
//   issue_valid, issue_idx       oldest ready entry, combinational from registered state
//   issue_ready                  issue stage takes issue_idx this cycle
//   perf_full_cyc, perf_issue_cnt  optional saturating counters, present only when the
//                                macro WAKEUP_PERF_CNT_EN is defined; reset by rst only
module wakeup_select_ctrl #(
  parameter int NUM_FUS     = 4,
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  input  logic                   src1_dp_en,
  input  logic                   src2_dp_en,
  input  logic [2*NUM_FUS-1:0]   src1_dp_loc,
  input  logic [2*NUM_FUS-1:0]   src2_dp_loc,
  output logic                   entry_free,
  output logic [IDX_W-1:0]       disp_idx,
  input  logic [2*NUM_FUS-1:0]   wakeup_vec,
  input  logic                   flush,
  output logic                   issue_valid,
  output logic [IDX_W-1:0]       issue_idx,
  input  logic                   issue_ready
`ifdef WAKEUP_PERF_CNT_EN
  ,
  output logic [31:0]            perf_full_cyc,
  output logic [31:0]            perf_issue_cnt
`endif
);

  localparam int MASK_W = 2 * NUM_FUS;
  localparam int CNT_W  = $clog2(NUM_ENTRIES + 1);

  typedef struct packed {
    logic              vld;
    logic [MASK_W-1:0] m1;
    logic [MASK_W-1:0] m2;
  } entry_t;

  entry_t                 ent_q   [NUM_ENTRIES];
  // older_q[i][j] = 1 means entry j was allocated before entry i. Bits that point at
  // invalid entries may be stale; they are always masked by the ready vector.
  logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;

  logic [NUM_ENTRIES-1:0] vld_vec;
  logic [NUM_ENTRIES-1:0] rdy_vec;
  logic [NUM_ENTRIES-1:0] sel_vec;
  logic [MASK_W-1:0]      m1_in;
  logic [MASK_W-1:0]      m2_in;
  logic                   do_disp;
  logic                   do_issue;

  // ---------------------------------------------------------------------------
  // Status derived from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_vec = '0;
    rdy_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      vld_vec[i] = ent_q[i].vld;
      rdy_vec[i] = ent_q[i].vld && (ent_q[i].m1 == '0) && (ent_q[i].m2 == '0);
    end
  end

  assign entry_free = (count_q != CNT_W'(NUM_ENTRIES));

  // Lowest-index free entry; scanning downward lets the lowest index win.
  always_comb begin
    disp_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!vld_vec[i]) disp_idx = IDX_W'(i);
    end
  end

  // Oldest-ready select: an entry wins when no ready entry is older than it.
  // Valid entries form a total order in older_q, so at most one bit of sel_vec is set.
  always_comb begin
    sel_vec   = '0;
    issue_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      sel_vec[i] = rdy_vec[i] && ((older_q[i] & rdy_vec) == '0);
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (sel_vec[i]) issue_idx = IDX_W'(i);
    end
  end

  assign issue_valid = |rdy_vec;

  // Flush squashes any same-cycle dispatch or issue.
  assign do_disp  = dispatch_valid && entry_free && !flush;
  assign do_issue = issue_valid && issue_ready && !flush;

  assign m1_in = src1_dp_en ? src1_dp_loc : '0;
  assign m2_in = src2_dp_en ? src2_dp_loc : '0;

  always_comb begin
    count_d = count_q;
    case ({do_disp, do_issue})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Entry, age-matrix and occupancy state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i]   <= '0;
        older_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        // Wakeup broadcast clears matching producer bits in every entry.
        ent_q[i].m1 <= ent_q[i].m1 & ~wakeup_vec;
        ent_q[i].m2 <= ent_q[i].m2 & ~wakeup_vec;

        if (do_issue && (issue_idx == IDX_W'(i))) begin
          ent_q[i].vld <= 1'b0;
        end

        // The allocated entry is never the issuing one (it is invalid), so these
        // writes cannot collide with the issue clear above.
        if (do_disp && (disp_idx == IDX_W'(i))) begin
          ent_q[i].vld <= 1'b1;
          ent_q[i].m1  <= m1_in & ~wakeup_vec;
          ent_q[i].m2  <= m2_in & ~wakeup_vec;
          older_q[i]   <= vld_vec;
        end

        // Newly allocated entry is younger than everyone: clear its column.
        if (do_disp && (disp_idx != IDX_W'(i))) begin
          older_q[i][disp_idx] <= 1'b0;
        end
      end
      count_q <= count_d;
    end
  end

`ifdef WAKEUP_PERF_CNT_EN
  // Counters survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_cyc  <= '0;
      perf_issue_cnt <= '0;
    end else begin
      if (!entry_free && (perf_full_cyc != '1)) begin
        perf_full_cyc <= perf_full_cyc + 32'd1;
      end
      if (do_issue && (perf_issue_cnt != '1)) begin
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Dispatch into a full scheduler is dropped by the RTL; flag it to the upstream owner.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(dispatch_valid && !entry_free))
        else $warning("wakeup_select_ctrl: dispatch_valid while entry_free==0, dispatch dropped");
    end
  end
`endif

endmodule
